// File: rtl/clz_share_arbiter.sv
// clz_share_arbiter
// Lets NUM_REQ requesters take turns on one combinational CountLeadingZeros
// unit. A round-robin arbiter accepts one word at a time. The word is
// registered onto the shared unit's input. The count is then returned on a
// single response channel, tagged with the owning requester's index.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req_valid   per-requester valid (bit i = requester i)
//   req_data    packed words, requester i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot (or zero) accept strobe, combinational in IDLE
//   clz_vec     registered operand for the shared CLZ unit
//   clz_result  count returned by the shared CLZ unit
//   rsp_valid   response valid
//   rsp_ready   response consumer ready
//   rsp_id      requester index owning the response
//   rsp_count   leading-zero count (DATA_W for an all-zero word)
module clz_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int RES_W   = 6,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         clz_vec,
  input  logic [RES_W-1:0]          clz_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RES_W-1:0]          rsp_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] rr_next;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  // Round-robin search starting at rr_ptr. The loop walks the offsets from
  // the farthest to the nearest, so the nearest active requester is the last
  // one written and therefore wins. The index is wrapped with a compare
  // rather than a modulo, which keeps the logic correct when NUM_REQ is not
  // a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[ID_W-1:0];
      end
    end
  end

  // Only IDLE may accept a word, and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  // After a response, the pointer moves just past the requester that was
  // served, wrapping from the last requester back to 0.
  assign rr_next = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // IDLE registers the granted word onto the shared unit. CALC gives the
  // unit one full cycle and captures its result. RESP holds the response
  // until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      clz_vec   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            clz_vec <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            owner   <= grant_idx;
            state   <= CALC;
          end
        end
        CALC: begin
          rsp_count <= clz_result;
          rsp_id    <= owner;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= rr_next;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clz_share_arbiter.sv
// tb_clz_share_arbiter
// Drives clz_share_arbiter together with a behavioural CountLeadingZeros
// unit. Inputs are driven on the falling edge. Every output is compared
// with a transaction-level reference model: a pointer, one in-flight job,
// and the cycle in which that job was accepted.
module tb_clz_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int RES_W   = 6;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         clz_vec;
  logic [RES_W-1:0]          clz_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [RES_W-1:0]          rsp_count;

  logic [DATA_W-1:0] drv_data [NUM_REQ];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cyc = 0;
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_acc = 0;
  int          m_owner = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_vec = '0;
  int          last_grant = -1;

  // observations recorded for the directed scenarios
  int obs_grant [$];
  int obs_grant_cyc [$];
  int obs_cnt [$];
  int obs_id [$];

  clz_share_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .RES_W(RES_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .clz_vec(clz_vec), .clz_result(clz_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_data[g*DATA_W +: DATA_W] = drv_data[g];
  end

  always #5 clk = ~clk;

  // Shared unit: the count is the position of the highest set bit, measured
  // from the MSB.
  function automatic logic [RES_W-1:0] clz_unit(input logic [DATA_W-1:0] v);
    int n;
    n = DATA_W;
    for (int b = 0; b < DATA_W; b++)
      if (v[b]) n = DATA_W - 1 - b;
    return RES_W'(n);
  endfunction

  assign clz_result = clz_unit(clz_vec);

  // Reference count: keep doubling the word until its MSB is set.
  function automatic int ref_clz(input logic [31:0] w);
    longint lv;
    int n;
    if (w == 0) return DATA_W;
    lv = longint'(w);
    n = 0;
    while (lv < (64'd1 << (DATA_W - 1))) begin
      lv = lv * 2;
      n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle. The task is called at a falling edge: it drives the
  // inputs, checks every output against the model, moves through the
  // rising edge, advances the model, and returns at the next falling edge.
  task automatic applyStimulus(input logic r, input logic [NUM_REQ-1:0] v, input logic rr);
    int exp_grant;
    logic [NUM_REQ-1:0] exp_ready;
    bit exp_rv;
    rst = r;
    req_valid = v;
    rsp_ready = rr;
    #1;
    exp_grant = -1;
    if (!r && !m_busy)
      for (int k = 0; k < NUM_REQ; k++)
        if (exp_grant < 0 && v[(m_ptr + k) % NUM_REQ]) exp_grant = (m_ptr + k) % NUM_REQ;
    exp_ready = (exp_grant >= 0) ? NUM_REQ'(1) << exp_grant : '0;
    exp_rv = m_busy && (cyc >= m_acc + 2);
    checkOutput("req_ready", req_ready, exp_ready);
    checkOutput("rsp_valid", rsp_valid, exp_rv);
    checkOutput("clz_vec", clz_vec, m_vec);
    if (exp_rv) begin
      checkOutput("rsp_id", rsp_id, m_owner);
      checkOutput("rsp_count", rsp_count, ref_clz(m_word));
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        obs_grant.push_back(i);
        obs_grant_cyc.push_back(cyc);
      end
    if (rsp_valid && rr && !r) begin
      obs_cnt.push_back(int'(rsp_count));
      obs_id.push_back(int'(rsp_id));
    end
    @(posedge clk);
    last_grant = exp_grant;
    if (r) begin
      m_busy = 0;
      m_ptr = 0;
      m_vec = '0;
    end else if (exp_grant >= 0) begin
      m_busy = 1;
      m_acc = cyc;
      m_owner = exp_grant;
      m_word = drv_data[exp_grant];
      m_vec = m_word;
    end else if (exp_rv && rr) begin
      m_busy = 0;
      m_ptr = (m_owner + 1) % NUM_REQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clearObs();
    obs_grant.delete();
    obs_grant_cyc.delete();
    obs_cnt.delete();
    obs_id.delete();
  endtask

  task automatic sendAndDrain(input int id, input logic [31:0] word);
    drv_data[id] = word;
    applyStimulus(1'b0, NUM_REQ'(1) << id, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [NUM_REQ-1:0] cur_v;
    for (int i = 0; i < NUM_REQ; i++) drv_data[i] = '0;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);

    // reset state
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("rst_id", rsp_id, 0);
    checkOutput("rst_count", rsp_count, 0);

    // single request
    clearObs();
    sendAndDrain(0, 32'h8000_0000);
    checkOutput("single_n", obs_cnt.size(), 1);
    checkOutput("single_cnt", obs_cnt[0], 0);
    checkOutput("single_id", obs_id[0], 0);

    // shift sweep on requester 2
    clearObs();
    for (int k = 0; k <= 32; k++)
      sendAndDrain(2, (k < 32) ? (32'h8000_0000 >> k) : 32'h0);
    checkOutput("sweep_n", obs_cnt.size(), 33);
    for (int k = 0; k <= 32; k++) begin
      checkOutput("sweep_cnt", obs_cnt[k], k);
      checkOutput("sweep_id", obs_id[k], 2);
    end

    // round-robin fairness from pointer 0
    applyStimulus(1'b1, '0, 1'b0);
    clearObs();
    for (int i = 0; i < NUM_REQ; i++) drv_data[i] = 32'h0000_0100 << i;
    for (int c = 0; c < 18; c++) applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("rr_n", obs_grant.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("rr_order", obs_grant[i], i % NUM_REQ);
      if (i > 0) checkOutput("rr_spacing", obs_grant_cyc[i] - obs_grant_cyc[i-1], 3);
    end

    // pointer skip: pointer 1 with requesters 0 and 3 active
    applyStimulus(1'b1, '0, 1'b0);
    sendAndDrain(0, 32'h0000_ffff);
    clearObs();
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 4'b1001, 1'b1);
    checkOutput("skip_n", obs_grant.size(), 2);
    checkOutput("skip_first", obs_grant[0], 3);
    checkOutput("skip_second", obs_grant[1], 0);

    // backpressure in RESP
    applyStimulus(1'b1, '0, 1'b0);
    drv_data[1] = 32'h0010_0000;
    applyStimulus(1'b0, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 4'b1111, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    clearObs();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("bp_next_grant", obs_grant.size() > 0 ? obs_grant[0] : -1, 2);

    // reset during CALC, then during RESP
    applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    drv_data[2] = 32'h1;
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    clearObs();
    applyStimulus(1'b0, 4'b1010, 1'b1);
    checkOutput("rst_calc_grant", obs_grant.size() > 0 ? obs_grant[0] : -1, 1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    clearObs();
    applyStimulus(1'b0, 4'b1100, 1'b1);
    checkOutput("rst_resp_grant", obs_grant.size() > 0 ? obs_grant[0] : -1, 2);
    checkOutput("rst_resp_norsp", obs_cnt.size(), 0);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b1);

    // randomized traffic; a word is held while its valid waits for acceptance
    cur_v = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cur_v[i] && last_grant != i) begin
          if ($urandom_range(0, 7) == 0) cur_v[i] = 1'b0;
        end else begin
          cur_v[i] = 1'($urandom_range(0, 1));
          drv_data[i] = $urandom >> $urandom_range(0, 32);
        end
      end
      applyStimulus(($urandom_range(0, 63) == 0), cur_v, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clz_share_arbiter.md
Name: clz_share_arbiter

Overview:
- Shares one combinational CountLeadingZeros unit (32-bit vec in, 6-bit result out) between NUM_REQ requesters.
- Each requester presents a data word with a valid/ready handshake; a round-robin arbiter grants one word at a time and drives it onto the shared unit.
- The returned count is delivered on a single response channel tagged with the requester ID.
- Used wherever several normalisation/priority paths need a CLZ and area forbids one unit per path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of each data word and of the shared unit's vec input.
- RES_W, 6, width of the count; must hold DATA_W (count 0..DATA_W).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester valid; bit i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  requester i word is req_data[i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot or zero; bit i high means requester i's word is accepted this cycle.
- clz_vec  out  DATA_W  registered operand driven to the shared CountLeadingZeros vec input.
- clz_result  in  RES_W  result from the shared unit, combinational from clz_vec.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_count  out  RES_W  leading-zero count; equals DATA_W when the word is 0.

Behaviour:
- FSM states: IDLE, CALC, RESP. On reset: state IDLE, rr_ptr 0, clz_vec 0, rsp_valid 0, rsp_id 0, rsp_count 0. req_ready is 0 while rst is high.
- Arbitration (IDLE only):
  - grant = first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle; all other bits are 0.
  - req_ready is 0 in every bit in CALC and RESP.
  - If no req_valid bit is set, stay in IDLE.
- Accept edge (IDLE with a grant):
  - clz_vec <= req_data[grant].
  - Latch grant into an internal owner register.
  - Next state CALC.
- CALC (exactly one cycle):
  - clz_vec is stable.
  - rsp_count <= clz_result; rsp_id <= owner; rsp_valid <= 1.
  - Next state RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_count are held stable until rsp_ready = 1.
  - On the rsp_valid & rsp_ready edge: rsp_valid <= 0, rr_ptr <= (owner+1) mod NUM_REQ, next state IDLE.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Latency and throughput:
  - If the accept is in cycle T, rsp_valid is high from cycle T+2.
  - With rsp_ready held at 1, the minimum issue interval is 3 cycles.
- The CountLeadingZeros unit outputs DATA_W for an all-zero word; this value is passed through unmodified. No saturation or other arithmetic is applied to clz_result.
- Requesters must hold req_data stable while req_valid is high and not yet accepted. Dropping req_valid before acceptance is allowed and removes that requester from arbitration.
- If rst is asserted in any state, the in-flight transaction is discarded without a response. All state returns to its reset values on that edge.
- rsp_ready is ignored while rsp_valid = 0.

Test Plan:
- Single request: after reset, req_valid=4'b0001 with word 0x80000000 -> req_ready=0001 in the accept cycle; rsp_valid two cycles later with rsp_id=0, rsp_count=0.
- Shift sweep: requester 2 sends 0x80000000 >> k for k=0..31, then 0 -> rsp_count equals k for each word, and 32 for the zero word; every rsp_id=2.
- Round-robin fairness: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0,1; responses spaced 3 cycles apart.
- Pointer skip: rr_ptr=1 with req_valid=4'b1001 -> requester 3 is granted; after its response, requester 0 is granted.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_count held stable, req_ready=0, no further accepts; rsp_ready=1 -> handshake, IDLE next cycle.
- Reset mid-operation: assert rst in CALC, and separately in RESP -> next cycle rsp_valid=0, req_ready=0, clz_vec=0; the first grant after reset goes to the lowest active index starting at 0.
